bus_arbiter: RTL and testbench
==============================

BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have parameter DMA_BURST_MAX, default 16, max consecutive DMA-granted cycles before the CPU regains the bus (range 1..255).
REQ-002 SHALL have ports:
clk_i  in  1  single clock, all state on rising edge.
rst_i  in  1  synchronous, active-high reset.
cpu_addr_i  in  32  processor address.
cpu_data_i  in  32  processor write data.
cpu_we_i  in  4  processor byte write enables.
cpu_stall_o  out  1  processor stall.
cpu_data_o  out  32  read data to processor.
dma_req_i  in  1  DMA bus request.
dma_addr_i  in  32  DMA address.
dma_data_i  in  32  DMA write data.
dma_we_i  in  4  DMA byte write enables.
dma_gnt_o  out  1  DMA owns bus this cycle.
dma_valid_o  out  1  dma_data_o holds read data for previous granted access.
dma_data_o  out  32  read data to DMA.
mem_addr_o  out  32  shared bus address.
mem_data_o  out  32  shared bus write data.
mem_we_o  out  4  shared bus byte write enables.
boot_cs_n_o  out  4  boot memory chip selects, active low.
ram_cs_n_o  out  4  RAM chip selects, active low.
periph_sel_o  out  1  peripheral select.
boot_data_i, ram_data_i, periph_data_i  in  32 each  target read data, valid one cycle after select.

Function
REQ-003 SHALL decode mem_addr_o[31:28]: 0x0 boot, 0x4 RAM, 0xE peripheral, other none.
REQ-004 SHALL drive the selected target's cs_n to 4'h0 (or periph_sel_o=1) and all others to 4'hF/0, combinationally from the current owner's address.
REQ-005 SHALL force mem_we_o=0 when region is boot or none; otherwise pass the owner's we.
REQ-006 SHALL implement FSM states CPU, DMA, RET; mem_* driven by CPU port in CPU and RET, by DMA port in DMA.
REQ-007 CPU->DMA when dma_req_i=1 sampled in CPU; DMA->RET when dma_req_i=0 or burst count reaches DMA_BURST_MAX; RET->CPU unconditionally.
REQ-008 dma_req_i SHALL be ignored in RET; earliest re-grant follows at least one CPU-state cycle.
REQ-009 dma_gnt_o=1 exactly in DMA; cpu_stall_o=1 in DMA and RET, 0 in CPU.
REQ-010 Burst counter SHALL clear on CPU->DMA and increment each DMA cycle; width ceil(log2(DMA_BURST_MAX+1)); exit after exactly DMA_BURST_MAX granted cycles.
REQ-011 SHALL register owner and region of each cycle's access (1-cycle delay); read data muxed by registered region, 32'h0 for none.
REQ-012 dma_valid_o=1 in the cycle after a DMA-state cycle with dma_we_i=0; cpu_data_o carries muxed data when registered owner is CPU, else holds last value.
REQ-013 CPU SHALL keep its address during stall; RET cycle returns the last DMA read and re-presents the CPU address, so no CPU access is lost.

Reset
REQ-014 While rst_i=1 at a clock edge: state CPU, counter 0, registered region none, dma_valid_o 0, cpu_data_o 0; outputs then: cs_n 4'hF, periph_sel_o 0, mem_we_o 0, cpu_stall_o 0, dma_gnt_o 0.
REQ-015 Reset mid-burst SHALL abort the DMA grant with no RET cycle and no dma_valid_o pulse.

Structure
REQ-016 Package bus_pkg SHALL hold region enum (BOOT, RAM, PERIPH, NONE), FSM state enum, and region nibble constants 0x0/0x4/0xE.
REQ-017 Address decode SHALL be sub-module bus_region_decode (combinational, address nibble -> region).

Verification
REQ-018 Reset, CPU read 0x40000010 -> ram_cs_n_o=4'h0, cpu_data_o=ram_data_i next cycle, stall 0.
REQ-019 CPU write we=4'hF to 0x00000100 -> mem_we_o=0, boot_cs_n_o=4'h0.
REQ-020 dma_req_i held high, DMA_BURST_MAX=4 -> gnt 4 cycles, RET 1 cycle, CPU 1 cycle, gnt again; stall high during DMA+RET.
REQ-021 DMA read 0xE0000020 then req drop -> dma_valid_o=1 in RET with periph_data_i; CPU address re-presented in RET.
REQ-022 rst_i asserted in 2nd DMA cycle -> next cycle state CPU, gnt 0, stall 0, dma_valid_o 0.
REQ-023 Access to 0x80000000 -> all cs_n 4'hF, periph_sel_o 0, read data 32'h0.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and constants for the CPU/DMA bus arbiter and its address decoder.
package bus_pkg;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int WE_W   = 4;

  localparam logic [3:0] BOOT_NIBBLE   = 4'h0;
  localparam logic [3:0] RAM_NIBBLE    = 4'h4;
  localparam logic [3:0] PERIPH_NIBBLE = 4'hE;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RAM    = 2'd1,
    PERIPH = 2'd2,
    NONE   = 2'd3
  } region_e;

  typedef enum logic [1:0] {
    CPU = 2'd0,
    DMA = 2'd1,
    RET = 2'd2
  } state_e;

  // Active-low chip-select bank for one target: all four banks on when it is the decoded region.
  function automatic logic [3:0] cs_n_for(input region_e region, input region_e target);
    return (region == target) ? 4'h0 : 4'hF;
  endfunction

endpackage

// File: rtl/bus_region_decode.sv
// Combinational map from the top address nibble to the target region.
module bus_region_decode
  import bus_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [1:0] region
);

  always_comb begin
    region = NONE;
    case (nibble)
      BOOT_NIBBLE:   region = BOOT;
      RAM_NIBBLE:    region = RAM;
      PERIPH_NIBBLE: region = PERIPH;
      default:       region = NONE;
    endcase
  end

endmodule

// File: rtl/bus_arbiter.sv
// Shares one memory bus between a CPU and a burst-limited DMA master, with
// region decode, write masking and one-cycle-late read-data return.
module bus_arbiter
  import bus_pkg::*;
#(
  parameter int DMA_BURST_MAX = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [DATA_W-1:0] cpu_data_i,
  input  logic [WE_W-1:0]   cpu_we_i,
  output logic              cpu_stall_o,
  output logic [DATA_W-1:0] cpu_data_o,
  input  logic              dma_req_i,
  input  logic [ADDR_W-1:0] dma_addr_i,
  input  logic [DATA_W-1:0] dma_data_i,
  input  logic [WE_W-1:0]   dma_we_i,
  output logic              dma_gnt_o,
  output logic              dma_valid_o,
  output logic [DATA_W-1:0] dma_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_data_o,
  output logic [WE_W-1:0]   mem_we_o,
  output logic [3:0]        boot_cs_n_o,
  output logic [3:0]        ram_cs_n_o,
  output logic              periph_sel_o,
  input  logic [DATA_W-1:0] boot_data_i,
  input  logic [DATA_W-1:0] ram_data_i,
  input  logic [DATA_W-1:0] periph_data_i
);

  localparam int CNT_W = $clog2(DMA_BURST_MAX + 1);

  state_e           state;
  logic [CNT_W-1:0] burst_cnt;
  logic             burst_last;
  logic             dma_own;
  logic [WE_W-1:0]  own_we;
  logic [1:0]       region_raw;
  region_e          region;
  logic             we_allowed;

  region_e          region_p1;
  logic             cpu_own_p1;
  logic             vld_p1;
  logic [DATA_W-1:0] rd_data_p1;
  logic [DATA_W-1:0] cpu_data_hold;

  // Stage 0: owner mux and address decode, all combinational off the current owner.
  assign dma_own    = (state == DMA);
  assign mem_addr_o = dma_own ? dma_addr_i : cpu_addr_i;
  assign mem_data_o = dma_own ? dma_data_i : cpu_data_i;
  assign own_we     = dma_own ? dma_we_i   : cpu_we_i;

  bus_region_decode u_decode (
    .nibble (mem_addr_o[ADDR_W-1:ADDR_W-4]),
    .region (region_raw)
  );

  assign region       = region_e'(region_raw);
  assign boot_cs_n_o  = cs_n_for(region, BOOT);
  assign ram_cs_n_o   = cs_n_for(region, RAM);
  assign periph_sel_o = (region == PERIPH);

  // Boot memory is read-only and unmapped space must never see a write strobe.
  assign we_allowed = (region == RAM) || (region == PERIPH);
  assign mem_we_o   = we_allowed ? own_we : '0;

  assign burst_last = (burst_cnt == CNT_W'(DMA_BURST_MAX - 1));

  // RET is a mandatory single CPU-address cycle that also drains the last DMA read.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= CPU;
      burst_cnt   <= '0;
      dma_gnt_o   <= 1'b0;
      cpu_stall_o <= 1'b0;
    end else begin
      case (state)
        CPU: begin
          if (dma_req_i) begin
            state       <= DMA;
            burst_cnt   <= '0;
            dma_gnt_o   <= 1'b1;
            cpu_stall_o <= 1'b1;
          end
        end
        DMA: begin
          burst_cnt <= burst_cnt + CNT_W'(1);
          if (!dma_req_i || burst_last) begin
            state       <= RET;
            dma_gnt_o   <= 1'b0;
            cpu_stall_o <= 1'b1;
          end
        end
        RET: begin
          state       <= CPU;
          dma_gnt_o   <= 1'b0;
          cpu_stall_o <= 1'b0;
        end
        default: begin
          state       <= CPU;
          dma_gnt_o   <= 1'b0;
          cpu_stall_o <= 1'b0;
        end
      endcase
    end
  end

  // Stage 1: targets answer one cycle after select, so owner/region are carried forward.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      region_p1  <= NONE;
      cpu_own_p1 <= 1'b1;
      vld_p1     <= 1'b0;
    end else begin
      region_p1  <= region;
      cpu_own_p1 <= !dma_own;
      vld_p1     <= dma_own && (dma_we_i == '0);
    end
  end

  always_comb begin
    rd_data_p1 = '0;
    case (region_p1)
      BOOT:    rd_data_p1 = boot_data_i;
      RAM:     rd_data_p1 = ram_data_i;
      PERIPH:  rd_data_p1 = periph_data_i;
      default: rd_data_p1 = '0;
    endcase
  end

  assign dma_data_o  = rd_data_p1;
  assign dma_valid_o = vld_p1;

  // The CPU's read bus keeps its last value across DMA-owned return cycles.
  assign cpu_data_o = cpu_own_p1 ? rd_data_p1 : cpu_data_hold;

  always_ff @(posedge clk_i) begin
    if (rst_i) cpu_data_hold <= '0;
    else       cpu_data_hold <= cpu_data_o;
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: decode vector table, burst/return corner
// sequences, and a randomized run against a cycle-level reference model.
module tb_bus_arbiter;

  localparam int MAX = 4;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] cpu_addr_i, cpu_data_i, dma_addr_i, dma_data_i;
  logic [3:0]  cpu_we_i, dma_we_i;
  logic        dma_req_i;
  logic [31:0] boot_data_i, ram_data_i, periph_data_i;
  logic        cpu_stall_o, dma_gnt_o, dma_valid_o, periph_sel_o;
  logic [31:0] cpu_data_o, dma_data_o, mem_addr_o, mem_data_o;
  logic [3:0]  mem_we_o, boot_cs_n_o, ram_cs_n_o;

  always #5 clk_i = ~clk_i;

  bus_arbiter #(.DMA_BURST_MAX(MAX)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .cpu_addr_i    (cpu_addr_i),
    .cpu_data_i    (cpu_data_i),
    .cpu_we_i      (cpu_we_i),
    .cpu_stall_o   (cpu_stall_o),
    .cpu_data_o    (cpu_data_o),
    .dma_req_i     (dma_req_i),
    .dma_addr_i    (dma_addr_i),
    .dma_data_i    (dma_data_i),
    .dma_we_i      (dma_we_i),
    .dma_gnt_o     (dma_gnt_o),
    .dma_valid_o   (dma_valid_o),
    .dma_data_o    (dma_data_o),
    .mem_addr_o    (mem_addr_o),
    .mem_data_o    (mem_data_o),
    .mem_we_o      (mem_we_o),
    .boot_cs_n_o   (boot_cs_n_o),
    .ram_cs_n_o    (ram_cs_n_o),
    .periph_sel_o  (periph_sel_o),
    .boot_data_i   (boot_data_i),
    .ram_data_i    (ram_data_i),
    .periph_data_i (periph_data_i)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // 0 boot, 1 ram, 2 periph, 3 none
  function automatic int region_of(input logic [31:0] a);
    case (a[31:28])
      4'h0:    return 0;
      4'h4:    return 1;
      4'hE:    return 2;
      default: return 3;
    endcase
  endfunction

  function automatic logic [31:0] read_of(input int r);
    case (r)
      0:       return boot_data_i;
      1:       return ram_data_i;
      2:       return periph_data_i;
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    a = $urandom;
    case ($urandom_range(0, 4))
      0:       a[31:28] = 4'h0;
      1:       a[31:28] = 4'h4;
      2:       a[31:28] = 4'hE;
      3:       a[31:28] = 4'h8;
      default: ;
    endcase
    return a;
  endfunction

  task automatic idle_inputs();
    cpu_addr_i = 32'h8000_0000; cpu_data_i = 32'h0; cpu_we_i = 4'h0;
    dma_req_i = 1'b0; dma_addr_i = 32'h8000_0000; dma_data_i = 32'h0; dma_we_i = 4'h0;
    boot_data_i = 32'hB007_0000; ram_data_i = 32'hAA11_0000; periph_data_i = 32'hEE22_0000;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    dma_req_i = 1'b0;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk_i); #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  we;
    logic [3:0]  boot;
    logic [3:0]  ram;
    logic        periph;
    logic [3:0]  mwe;
    int          rsel;
  } vec_t;

  vec_t vecs[8];

  logic exp_gnt[9];
  logic exp_stall[9];

  // reference model state
  bit          m_gnt, m_ret;
  int          m_run;
  int          p_region;
  bit          p_dma, p_rd;
  logic [31:0] m_cpu;

  initial begin
    vecs[0] = '{32'h4000_0010, 4'h0, 4'hF, 4'h0, 1'b0, 4'h0, 1};
    vecs[1] = '{32'h0000_0100, 4'hF, 4'h0, 4'hF, 1'b0, 4'h0, 0};
    vecs[2] = '{32'hE000_0004, 4'h3, 4'hF, 4'hF, 1'b1, 4'h3, 2};
    vecs[3] = '{32'h8000_0000, 4'hF, 4'hF, 4'hF, 1'b0, 4'h0, 3};
    vecs[4] = '{32'h4FFF_FFFC, 4'hF, 4'hF, 4'h0, 1'b0, 4'hF, 1};
    vecs[5] = '{32'hF000_0000, 4'h5, 4'hF, 4'hF, 1'b0, 4'h0, 3};
    vecs[6] = '{32'h3FFF_FFFF, 4'hC, 4'hF, 4'hF, 1'b0, 4'h0, 3};
    vecs[7] = '{32'hEFFF_0000, 4'h8, 4'hF, 4'hF, 1'b1, 4'h8, 2};

    idle_inputs();
    cpu_we_i = 4'hF;

    // reset state
    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_stall", 32'(cpu_stall_o), 32'h0);
    chk("rst_gnt", 32'(dma_gnt_o), 32'h0);
    chk("rst_dma_valid", 32'(dma_valid_o), 32'h0);
    chk("rst_cpu_data", cpu_data_o, 32'h0);
    chk("rst_boot_cs", 32'(boot_cs_n_o), 32'hF);
    chk("rst_ram_cs", 32'(ram_cs_n_o), 32'hF);
    chk("rst_periph", 32'(periph_sel_o), 32'h0);
    chk("rst_mem_we", 32'(mem_we_o), 32'h0);
    #1;
    rst_i = 1'b0;
    cpu_we_i = 4'h0;
    next_cycle();

    // decode table in CPU ownership, read data checked one cycle later
    for (int i = 0; i < 8; i++) begin
      cpu_addr_i = vecs[i].addr;
      cpu_we_i = vecs[i].we;
      cpu_data_i = 32'h1000_0000 + 32'(i);
      boot_data_i = 32'hB000_0000 + 32'(i);
      ram_data_i = 32'hA000_0000 + 32'(i);
      periph_data_i = 32'hE000_0000 + 32'(i);
      @(negedge clk_i);
      chk("vec_boot_cs", 32'(boot_cs_n_o), 32'(vecs[i].boot));
      chk("vec_ram_cs", 32'(ram_cs_n_o), 32'(vecs[i].ram));
      chk("vec_periph", 32'(periph_sel_o), 32'(vecs[i].periph));
      chk("vec_mem_we", 32'(mem_we_o), 32'(vecs[i].mwe));
      chk("vec_mem_addr", mem_addr_o, vecs[i].addr);
      chk("vec_mem_data", mem_data_o, 32'h1000_0000 + 32'(i));
      chk("vec_stall", 32'(cpu_stall_o), 32'h0);
      next_cycle();
      cpu_addr_i = 32'h8000_0000;
      cpu_we_i = 4'h0;
      @(negedge clk_i);
      chk("vec_cpu_data", cpu_data_o, read_of(vecs[i].rsel));
      next_cycle();
    end

    // request held: MAX grants, one RET, one CPU, then grant again
    do_reset();
    exp_gnt   = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    exp_stall = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    cpu_addr_i = 32'h4000_0000;
    dma_addr_i = 32'h4000_1000;
    dma_we_i = 4'hF;
    dma_req_i = 1'b1;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk_i);
      chk("burst_gnt", 32'(dma_gnt_o), 32'(exp_gnt[c]));
      chk("burst_stall", 32'(cpu_stall_o), 32'(exp_stall[c]));
      chk("burst_mem_addr", mem_addr_o, exp_gnt[c] ? 32'h4000_1000 : 32'h4000_0000);
      next_cycle();
    end
    dma_req_i = 1'b0;
    dma_we_i = 4'h0;

    // single DMA peripheral read, request dropped, data returned in RET
    do_reset();
    cpu_addr_i = 32'h4000_0040;
    cpu_we_i = 4'h0;
    dma_req_i = 1'b1;
    @(negedge clk_i);
    chk("ret_pre_gnt", 32'(dma_gnt_o), 32'h0);
    next_cycle();
    dma_addr_i = 32'hE000_0020;
    dma_we_i = 4'h0;
    dma_req_i = 1'b0;
    @(negedge clk_i);
    chk("ret_dma_gnt", 32'(dma_gnt_o), 32'h1);
    chk("ret_dma_periph", 32'(periph_sel_o), 32'h1);
    chk("ret_dma_addr", mem_addr_o, 32'hE000_0020);
    next_cycle();
    periph_data_i = 32'hCAFE_F00D;
    ram_data_i = 32'h0BAD_BEEF;
    @(negedge clk_i);
    chk("ret_valid", 32'(dma_valid_o), 32'h1);
    chk("ret_dma_data", dma_data_o, 32'hCAFE_F00D);
    chk("ret_cpu_addr", mem_addr_o, 32'h4000_0040);
    chk("ret_ram_cs", 32'(ram_cs_n_o), 32'h0);
    chk("ret_stall", 32'(cpu_stall_o), 32'h1);
    chk("ret_gnt", 32'(dma_gnt_o), 32'h0);
    next_cycle();
    ram_data_i = 32'h5555_AAAA;
    @(negedge clk_i);
    chk("post_ret_cpu_data", cpu_data_o, 32'h5555_AAAA);
    chk("post_ret_stall", 32'(cpu_stall_o), 32'h0);
    chk("post_ret_valid", 32'(dma_valid_o), 32'h0);
    next_cycle();

    // reset in the second DMA cycle aborts without RET or valid pulse
    do_reset();
    cpu_addr_i = 32'h4000_0000;
    dma_addr_i = 32'h4000_0200;
    dma_we_i = 4'h0;
    dma_req_i = 1'b1;
    next_cycle();
    next_cycle();
    @(negedge clk_i);
    chk("abort_pre_gnt", 32'(dma_gnt_o), 32'h1);
    #1;
    rst_i = 1'b1;
    next_cycle();
    rst_i = 1'b0;
    dma_req_i = 1'b0;
    @(negedge clk_i);
    chk("abort_gnt", 32'(dma_gnt_o), 32'h0);
    chk("abort_stall", 32'(cpu_stall_o), 32'h0);
    chk("abort_valid", 32'(dma_valid_o), 32'h0);
    chk("abort_cpu_data", cpu_data_o, 32'h0);
    next_cycle();
    @(negedge clk_i);
    chk("abort_no_ret", 32'(cpu_stall_o), 32'h0);
    chk("abort_no_valid", 32'(dma_valid_o), 32'h0);
    next_cycle();

    // randomized run against the reference model
    do_reset();
    m_gnt = 0; m_ret = 0; m_run = 0;
    p_region = 3; p_dma = 0; p_rd = 0; m_cpu = 32'h0;
    for (int c = 0; c < 1500; c++) begin
      logic [31:0] own_addr, exp_rd, exp_cpu;
      logic [3:0]  own_we, exp_we;
      int          r;
      cpu_addr_i = rand_addr();
      dma_addr_i = rand_addr();
      cpu_data_i = $urandom;
      dma_data_i = $urandom;
      cpu_we_i = 4'($urandom);
      dma_we_i = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
      dma_req_i = ($urandom_range(0, 3) != 0);
      rst_i = ($urandom_range(0, 99) == 0);
      boot_data_i = $urandom;
      ram_data_i = $urandom;
      periph_data_i = $urandom;
      @(negedge clk_i);
      own_addr = m_gnt ? dma_addr_i : cpu_addr_i;
      own_we = m_gnt ? dma_we_i : cpu_we_i;
      r = region_of(own_addr);
      exp_we = (r == 1 || r == 2) ? own_we : 4'h0;
      exp_rd = read_of(p_region);
      exp_cpu = p_dma ? m_cpu : exp_rd;
      chk("rnd_gnt", 32'(dma_gnt_o), 32'(m_gnt));
      chk("rnd_stall", 32'(cpu_stall_o), 32'(m_gnt || m_ret));
      chk("rnd_mem_addr", mem_addr_o, own_addr);
      chk("rnd_mem_data", mem_data_o, m_gnt ? dma_data_i : cpu_data_i);
      chk("rnd_mem_we", 32'(mem_we_o), 32'(exp_we));
      chk("rnd_boot_cs", 32'(boot_cs_n_o), (r == 0) ? 32'h0 : 32'hF);
      chk("rnd_ram_cs", 32'(ram_cs_n_o), (r == 1) ? 32'h0 : 32'hF);
      chk("rnd_periph", 32'(periph_sel_o), 32'(r == 2));
      chk("rnd_valid", 32'(dma_valid_o), 32'(p_rd));
      chk("rnd_cpu_data", cpu_data_o, exp_cpu);
      if (p_rd) chk("rnd_dma_data", dma_data_o, exp_rd);
      @(posedge clk_i);
      if (rst_i) begin
        m_gnt = 0; m_ret = 0; m_run = 0;
        p_region = 3; p_dma = 0; p_rd = 0; m_cpu = 32'h0;
      end else begin
        p_region = r;
        p_dma = m_gnt;
        p_rd = m_gnt && (dma_we_i == 4'h0);
        m_cpu = exp_cpu;
        if (m_gnt) begin
          m_run++;
          if (!dma_req_i || m_run == MAX) begin
            m_gnt = 0;
            m_ret = 1;
          end
        end else if (m_ret) begin
          m_ret = 0;
        end else if (dma_req_i) begin
          m_gnt = 1;
          m_run = 0;
        end
      end
      #1;
    end
    rst_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
